// File: rtl/mem_bridge_pkg.sv
// Shared op codes, response error codes, FSM encoding and request-decode helpers
// for the CPU-to-data-RAM bridge.
package mem_bridge_pkg;

    localparam logic [2:0] OP_B  = 3'd0;
    localparam logic [2:0] OP_H  = 3'd1;
    localparam logic [2:0] OP_W  = 3'd2;
    localparam logic [2:0] OP_BS = 3'd4;
    localparam logic [2:0] OP_HS = 3'd5;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // Signed variants only make sense for loads; a signed store is rejected.
    function automatic logic op_illegal(input logic we, input logic [2:0] op);
        case (op)
            OP_B, OP_H, OP_W: return 1'b0;
            OP_BS, OP_HS:     return we;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_H, OP_HS: return addr_lo[0];
            OP_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_bridge_wdog.sv
// Access watchdog: counts cycles while enabled, held at zero while cleared, and
// flags expiry on the last allowed cycle (TIMEOUT_CYCLES-1).
module mem_bridge_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// Load/store request/response bridge to the byte-lane data RAM controller.
// Build option MEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses with ERR_MISALIGN.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic [1:0]        rsp_err_o,
    output logic              mem_d_en_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [2:0]        mem_op_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i
);

    state_e            state_q;
    logic              d_en_q, re_q, we_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic [1:0]        rsp_err_q;
    logic              expire;

    mem_bridge_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (state_q != StAccess),
        .en_i    (state_q == StAccess),
        .expire_o(expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            d_en_q      <= 1'b0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        op_q        <= req_op_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        rsp_rdata_q <= '0;
                        if (op_illegal(req_we_i, req_op_i)) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ERR_ILLEGAL;
                        end
`ifdef MEM_MISALIGN_TRAP_EN
                        else if (op_misaligned(req_op_i, req_addr_i[1:0])) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ERR_MISALIGN;
                        end
`endif
                        else begin
                            state_q <= StAccess;
                            d_en_q  <= 1'b1;
                            re_q    <= ~req_we_i;
                            we_q    <= req_we_i;
                        end
                    end
                end
                StAccess: begin
                    // Strobes drop on the ready edge so the RAM's ready FSM does not re-arm.
                    if (mem_ready_i) begin
                        state_q     <= StResp;
                        d_en_q      <= 1'b0;
                        re_q        <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= re_q ? mem_rdata_i : 32'h0;
                        rsp_err_q   <= ERR_OK;
                    end else if (expire) begin
                        state_q     <= StResp;
                        d_en_q      <= 1'b0;
                        re_q        <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= ERR_TIMEOUT;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign mem_d_en_o  = d_en_q;
    assign mem_re_o    = re_q;
    assign mem_we_o    = we_q;
    assign mem_op_o    = op_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
Request/response bridge between the CPU load/store stage and the byte-lane data RAM controller.
- Accepts one load or store on a valid/ready request channel.
- Drives the RAM strobes (d_en/re/we/mem_op/addr/wdata) and holds them stable until the RAM's one-cycle ready pulse.
- Captures read data and returns it on a valid/ready response channel.
- Adds a timeout watchdog and illegal-op rejection, so a stuck or bad access never hangs the pipeline.

Parameters:
TIMEOUT_CYCLES, 16, cycles in ACCESS without mem_ready before the access is aborted (min 4).
ADDR_W, 32, address width.

Ports:
clk  input  1  core clock; the RAM controller and its ready FSM run on the same clock.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  bridge can accept a request; high only in IDLE.
req_we  input  1  1=store, 0=load.
req_op  input  3  0 byte, 1 half, 2 word, 4 byte signed, 5 half signed.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data, LSB-aligned.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer takes the response.
rsp_rdata  output  32  load data; 0 for stores and errors.
rsp_err  output  2  0 ok, 1 timeout, 2 misaligned, 3 illegal op.
mem_d_en  output  1  RAM data enable.
mem_re  output  1  RAM read strobe.
mem_we  output  1  RAM write strobe.
mem_op  output  3  registered copy of req_op.
mem_addr  output  ADDR_W  registered address.
mem_wdata  output  32  registered store data.
mem_rdata  input  32  RAM read data; combinational, valid only while mem_re and mem_d_en are high.
mem_ready  input  1  one-cycle completion pulse from the RAM.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all strobes 0; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_op/addr/wdata=0; timeout counter=0.
  - Strobes drop immediately, even mid-access.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/op/addr/wdata.
  - If op is 3, 6 or 7: go to RESP with rsp_err=3; no strobes asserted.
  - Stores with op 4 or 5 are also illegal (err 3).
  - Otherwise go to ACCESS. On the same edge set mem_d_en=1, mem_re=~we, mem_we=we.
- ACCESS:
  - Strobes, op, addr and wdata are held constant.
  - The timeout counter increments every cycle.
  - On mem_ready=1: capture rsp_rdata = mem_rdata for a load, or 0 for a store. Set rsp_err=0. Clear all strobes on that same edge, so the RAM ready FSM sees e=0 and does not restart. Go to RESP.
  - On counter reaching TIMEOUT_CYCLES-1 with no mem_ready: clear strobes, rsp_rdata=0, rsp_err=1, go to RESP.
  - If mem_ready and timeout coincide, mem_ready wins.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held until rsp_ready.
  - On handshake: rsp_valid=0, go to IDLE, counter=0.
  - No new request is accepted in the handshake cycle.
- Latency with the RAM's fixed two-cycle ready:
  - accept edge T0; strobes high T1-T3; mem_ready in T3; rsp_valid from T4.
  - Request-to-request throughput is 5 cycles with rsp_ready tied high.
- mem_ready seen outside ACCESS is ignored.
- Sign and zero extension come from the RAM; the bridge does not modify rdata.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: in IDLE, these requests are rejected:
  - half/half-signed with addr[0]=1;
  - word with addr[1:0]!=0.
  - A rejected request goes directly to RESP with rsp_err=2 and rsp_rdata=0; no strobes are asserted.
- Undefined: misaligned requests pass through unchanged; the RAM rotates byte lanes itself. rsp_err=2 is never produced.

Decomposition:
- Package mem_bridge_pkg holds:
  - mem_op constants: OP_B=0, OP_H=1, OP_W=2, OP_BU... and signed variants 4 and 5;
  - rsp_err codes: ERR_OK, ERR_TIMEOUT, ERR_MISALIGN, ERR_ILLEGAL;
  - the state encoding.
- One natural sub-module: mem_bridge_wdog, the loadable timeout counter with clear/enable and an expire flag.

Test Plan:
- Word load at 0x0000_0010 (req_op=2), RAM model returns 0xDEADBEEF with mem_ready 2 cycles after mem_re -> rsp_valid at T4, rsp_rdata=0xDEADBEEF, rsp_err=0, mem_re low the cycle after mem_ready.
- Byte store to 0x13 with wdata=0x0000_00A5 -> mem_we=1, mem_d_en=1, mem_op=0, mem_addr=0x13 held 3 cycles; response rsp_rdata=0, err=0.
- RAM never pulses ready, TIMEOUT_CYCLES=16 -> strobes drop after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0; next request accepted normally.
- req_op=7 load, then store with op=4 -> each gives rsp_err=3 one cycle after accept; mem_d_en never rises.
- rsp_ready held low 10 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; rst_n pulsed low in ACCESS of the next load -> strobes 0 immediately, state IDLE, no response.
- With MEM_MISALIGN_TRAP_EN: word load at 0x02 -> rsp_err=2, no strobes. Without it: same request reaches the RAM with mem_addr=0x02 and err=0.
